alu: RTL and testbench

- RV32I integer ALU for the execute stage.
- Decodes opcode/funct3/funct7 directly and computes the arithmetic, logic, shift and compare result.
- Also computes the branch/jump-taken flag.
- Outputs are registered: one cycle of latency, with asynchronous active-low reset.

---
 rtl/alu_if.sv | 22 ++
 rtl/alu.sv | 105 ++++++++++
 tb/tb_alu.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Execute-stage ALU bus: decoded instruction fields and operands in, registered result/branch out.
interface alu_if #(
  parameter int XLEN = 32
);
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] result;
  logic            branch;

  modport master (
    output opcode, funct3, funct7, src_a, src_b,
    input  result, branch
  );

  modport slave (
    input  opcode, funct3, funct7, src_a, src_b,
    output result, branch
  );
endinterface

// File: rtl/alu.sv
// RV32I integer ALU: decodes opcode/funct3/funct7, computes result and branch-taken flag,
// both registered with one cycle of latency.
module alu #(
  parameter int XLEN = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic [XLEN-1:0] result_d, result_q;
  logic            branch_d, branch_q;

  logic [4:0]      shamt;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic            lt_signed;
  logic            lt_unsigned;
  logic            alt;
  logic [XLEN-1:0] alu_op_result;
  logic            unused_funct7;

  assign shamt         = bus.src_b[4:0];
  assign sum           = bus.src_a + bus.src_b;
  assign diff          = bus.src_a - bus.src_b;
  assign lt_signed     = $signed(bus.src_a) < $signed(bus.src_b);
  assign lt_unsigned   = bus.src_a < bus.src_b;
  assign alt           = bus.funct7[5];
  assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

  // Shared R/I funct3 decode; subtract is only legal for the register form.
  always_comb begin
    alu_op_result = '0;
    unique case (bus.funct3)
      3'b000: alu_op_result = (alt && bus.opcode == OP_R) ? diff : sum;
      3'b001: alu_op_result = bus.src_a << shamt;
      3'b010: alu_op_result = {{(XLEN-1){1'b0}}, lt_signed};
      3'b011: alu_op_result = {{(XLEN-1){1'b0}}, lt_unsigned};
      3'b100: alu_op_result = bus.src_a ^ bus.src_b;
      3'b101: alu_op_result = alt ? XLEN'($signed(bus.src_a) >>> shamt)
                                  : bus.src_a >> shamt;
      3'b110: alu_op_result = bus.src_a | bus.src_b;
      3'b111: alu_op_result = bus.src_a & bus.src_b;
      default: alu_op_result = '0;
    endcase
  end

  always_comb begin
    result_d = '0;
    branch_d = 1'b0;
    case (bus.opcode)
      OP_R, OP_I: result_d = alu_op_result;
      OP_BRANCH: begin
        result_d = diff;
        case (bus.funct3)
          3'b000:  branch_d = (bus.src_a == bus.src_b);
          3'b001:  branch_d = (bus.src_a != bus.src_b);
          3'b100:  branch_d = lt_signed;
          3'b101:  branch_d = !lt_signed;
          3'b110:  branch_d = lt_unsigned;
          3'b111:  branch_d = !lt_unsigned;
          default: branch_d = 1'b0;
        endcase
      end
      OP_JAL: begin
        result_d = sum;
        branch_d = 1'b1;
      end
      OP_JALR: begin
        result_d = {sum[XLEN-1:1], 1'b0};
        branch_d = 1'b1;
      end
      OP_LOAD, OP_STORE, OP_AUIPC: result_d = sum;
      OP_LUI:  result_d = bus.src_b;
      default: begin
        result_d = '0;
        branch_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      branch_q <= 1'b0;
    end else begin
      result_q <= result_d;
      branch_q <= branch_d;
    end
  end

  assign bus.result = result_q;
  assign bus.branch = branch_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered RV32I ALU.
module tb_alu;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_if #(.XLEN(32)) bus ();

  alu #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive an operation on the falling edge, then let one rising edge register it.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge clk);
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.src_a  = a;
    bus.src_b  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] exp_result,
                             input logic exp_branch);
    checks++;
    assert (bus.result === exp_result) else begin
      failures++;
      $error("[TB] FAIL %s result got=%h exp=%h", tag, bus.result, exp_result);
    end
    checks++;
    assert (bus.branch === exp_branch) else begin
      failures++;
      $error("[TB] FAIL %s branch got=%b exp=%b", tag, bus.branch, exp_branch);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    bus.opcode = '0;
    bus.funct3 = '0;
    bus.funct7 = '0;
    bus.src_a  = '0;
    bus.src_b  = '0;
    #12;
    checkOutput("reset_initial", 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(OP_R, 3'b000, 7'h00, 32'd5, 32'd6);
    checkOutput("add", 32'd11, 1'b0);
    applyStimulus(OP_R, 3'b000, F7_ALT, 32'd567, 32'd6);
    checkOutput("sub", 32'd561, 1'b0);
    applyStimulus(OP_R, 3'b110, 7'h00, 32'd5, 32'd6);
    checkOutput("or", 32'd7, 1'b0);
    applyStimulus(OP_R, 3'b111, 7'h00, 32'd5, 32'd6);
    checkOutput("and", 32'd4, 1'b0);
    applyStimulus(OP_R, 3'b100, 7'h00, 32'd5, 32'd6);
    checkOutput("xor", 32'd3, 1'b0);
    applyStimulus(OP_I, 3'b000, F7_ALT, 32'd5, 32'd7);
    checkOutput("addi_no_sub", 32'd12, 1'b0);

    applyStimulus(OP_R, 3'b101, 7'h00, 32'h87654321, 32'd8);
    checkOutput("srl", 32'h00876543, 1'b0);
    applyStimulus(OP_R, 3'b101, F7_ALT, 32'h87654321, 32'd8);
    checkOutput("sra", 32'hFF876543, 1'b0);
    applyStimulus(OP_I, 3'b101, F7_ALT, 32'h87654321, 32'd8);
    checkOutput("srai", 32'hFF876543, 1'b0);
    applyStimulus(OP_R, 3'b001, 7'h00, 32'h12345678, 32'd8);
    checkOutput("sll", 32'h34567800, 1'b0);
    applyStimulus(OP_R, 3'b101, 7'h00, 32'h87654321, 32'h28);
    checkOutput("srl_shamt_mask", 32'h00876543, 1'b0);

    applyStimulus(OP_R, 3'b010, 7'h00, 32'h12345678, 32'h0000FFFF);
    checkOutput("slt_pos", 32'd0, 1'b0);
    applyStimulus(OP_R, 3'b011, 7'h00, 32'h12345678, 32'h0000FFFF);
    checkOutput("sltu_pos", 32'd0, 1'b0);
    applyStimulus(OP_R, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1);
    checkOutput("slt_neg", 32'd1, 1'b0);
    applyStimulus(OP_R, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1);
    checkOutput("sltu_big", 32'd0, 1'b0);

    applyStimulus(OP_BRANCH, 3'b000, 7'h00, 32'd8, 32'd87);
    checkOutput("beq_ne", 32'hFFFFFFB1, 1'b0);
    applyStimulus(OP_BRANCH, 3'b000, 7'h00, 32'd87, 32'd87);
    checkOutput("beq_eq", 32'h0, 1'b1);
    applyStimulus(OP_BRANCH, 3'b001, 7'h00, 32'd8, 32'd87);
    checkOutput("bne", 32'hFFFFFFB1, 1'b1);
    applyStimulus(OP_BRANCH, 3'b100, 7'h00, 32'd908, 32'd87);
    checkOutput("blt_not", 32'h00000335, 1'b0);
    applyStimulus(OP_BRANCH, 3'b100, 7'h00, 32'd8, 32'd87);
    checkOutput("blt_taken", 32'hFFFFFFB1, 1'b1);
    applyStimulus(OP_BRANCH, 3'b110, 7'h00, 32'hFFFFFFFF, 32'd1);
    checkOutput("bltu", 32'hFFFFFFFE, 1'b0);
    applyStimulus(OP_BRANCH, 3'b101, 7'h00, 32'hFFFFFFFF, 32'd1);
    checkOutput("bge", 32'hFFFFFFFE, 1'b0);
    applyStimulus(OP_BRANCH, 3'b111, 7'h00, 32'hFFFFFFFF, 32'd1);
    checkOutput("bgeu", 32'hFFFFFFFE, 1'b1);
    applyStimulus(OP_BRANCH, 3'b010, 7'h00, 32'd87, 32'd87);
    checkOutput("branch_f3_010", 32'h0, 1'b0);

    applyStimulus(OP_JALR, 3'b000, 7'h00, 32'h00000101, 32'h00000002);
    checkOutput("jalr", 32'h00000102, 1'b1);
    applyStimulus(OP_LUI, 3'b000, 7'h00, 32'h11111111, 32'hABCDE000);
    checkOutput("lui", 32'hABCDE000, 1'b0);
    applyStimulus(OP_LOAD, 3'b010, 7'h00, 32'h00001000, 32'h00000004);
    checkOutput("load", 32'h00001004, 1'b0);
    applyStimulus(OP_STORE, 3'b010, F7_ALT, 32'h00002000, 32'hFFFFFFFC);
    checkOutput("store", 32'h00001FFC, 1'b0);
    applyStimulus(OP_AUIPC, 3'b000, 7'h00, 32'h00400000, 32'h12345000);
    checkOutput("auipc", 32'h12745000, 1'b0);
    applyStimulus(7'h7F, 3'b000, 7'h00, 32'h12345678, 32'h9ABCDEF0);
    checkOutput("undefined_op", 32'h0, 1'b0);
    applyStimulus(OP_JAL, 3'b000, 7'h00, 32'h12345678, 32'h0000FFFF);
    checkOutput("jal", 32'h12355677, 1'b1);

    // Asynchronous reset while JAL outputs are nonzero, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async", 32'h0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset_held", 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(OP_R, 3'b000, 7'h00, 32'd5, 32'd6);
    checkOutput("add_after_reset", 32'd11, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
